result_bank_reader: RTL



---
 rtl/result_bank_reader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/result_bank_reader.sv
// Drains N result BRAM banks in row-major order (address outer, bank inner) into one
// valid/ready stream, hiding the 1-cycle BRAM latency behind a 2-entry credit buffer.
module result_bank_reader #(
    parameter int unsigned D_W          = 32,
    parameter int unsigned N            = 4,
    parameter int unsigned MATRIXSIZE_W = 16,
    parameter int unsigned ADDR_W       = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MATRIXSIZE_W-1:0] M1xM3dN1,
    output logic [N*ADDR_W-1:0]     rd_addr_bram,
    output logic [N-1:0]            rd_en_bram,
    input  logic [N*D_W-1:0]        rd_data_bram,
    output logic [D_W-1:0]          m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned B_W = $clog2(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [MATRIXSIZE_W-1:0] size_q, size_d;
    logic [MATRIXSIZE_W-1:0] a_q, a_d;
    logic [B_W-1:0]          b_q, b_d;
    logic                    busy_q, busy_d;

    logic                    inflight_q;
    logic [B_W-1:0]          inf_b_q;
    logic                    inf_last_q;

    logic [1:0]              occ_q, occ_d;
    logic                    valid_q, valid_d;
    logic [D_W-1:0]          s0_data_q, s0_data_d, s1_data_q, s1_data_d;
    logic                    s0_last_q, s0_last_d, s1_last_q, s1_last_d;

    logic                    pop;
    logic                    issue;
    logic                    last_issue;
    logic [D_W-1:0]          push_data;

    // Credit: buffer slots already claimed by held words and the read in flight.
    assign pop        = valid_q && m_tready;
    assign issue      = (state_q == S_RUN) &&
                        ((3'(occ_q) + 3'(inflight_q) - 3'(pop)) < 3'd2);
    assign last_issue = (a_q == size_q - MATRIXSIZE_W'(1)) && (b_q == B_W'(N - 1));
    assign push_data  = rd_data_bram[32'(inf_b_q) * D_W +: D_W];

    assign rd_en_bram   = issue ? (N'(1) << b_q) : '0;
    assign rd_addr_bram = {N{ADDR_W'(a_q)}};

    assign m_tdata  = s0_data_q;
    assign m_tlast  = s0_last_q;
    assign m_tvalid = valid_q;
    assign busy     = busy_q;
    assign done     = (state_q == S_DONE);

    // Sequencer: walks (a, b) and tracks the drain lifecycle.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    size_d  = M1xM3dN1;
                    a_d     = '0;
                    b_d     = '0;
                    busy_d  = 1'b1;
                    state_d = (M1xM3dN1 == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (b_q == B_W'(N - 1)) begin
                        b_d = '0;
                        a_d = a_q + MATRIXSIZE_W'(1);
                    end else begin
                        b_d = b_q + B_W'(1);
                    end
                    if (last_issue) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && s0_last_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Two-entry shift buffer; slot 0 is the head presented downstream.
    always_comb begin
        occ_d     = occ_q;
        s0_data_d = s0_data_q;
        s0_last_d = s0_last_q;
        s1_data_d = s1_data_q;
        s1_last_d = s1_last_q;
        case ({inflight_q, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    s0_data_d = push_data;
                    s0_last_d = inf_last_q;
                end else begin
                    s1_data_d = push_data;
                    s1_last_d = inf_last_q;
                end
            end
            2'b01: begin
                occ_d     = occ_q - 2'd1;
                s0_data_d = s1_data_q;
                s0_last_d = s1_last_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    s0_data_d = push_data;
                    s0_last_d = inf_last_q;
                end else begin
                    s0_data_d = s1_data_q;
                    s0_last_d = s1_last_q;
                    s1_data_d = push_data;
                    s1_last_d = inf_last_q;
                end
            end
            default: ;
        endcase
        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            size_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            busy_q     <= 1'b0;
            inflight_q <= 1'b0;
            inf_b_q    <= '0;
            inf_last_q <= 1'b0;
            occ_q      <= '0;
            valid_q    <= 1'b0;
            s0_data_q  <= '0;
            s0_last_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_q     <= busy_d;
            inflight_q <= issue;
            inf_b_q    <= b_q;
            inf_last_q <= issue && last_issue;
            occ_q      <= occ_d;
            valid_q    <= valid_d;
            s0_data_q  <= s0_data_d;
            s0_last_q  <= s0_last_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
        end
    end

endmodule
